// File: rtl/interpolation_unit_win_interp_ctrl.sv
// ---------------------------------------------------------------------------
// interpolation_unit_win_interp_ctrl
//
// Control FSM for the bilinear interpolation datapath. Streams a (W+1)x(W+1)
// pixel window (W latched from win_dim when a window starts) for NUM_CH
// channels in lock-step. It drives line-buffer push/pop, the coefficient
// latch and the pipeline enables, and produces W*W interpolated samples.
// Full valid/ready backpressure is supported on both sides.
//
// Parameters
//   WIN_MAX    largest legal win_dim; counters are $clog2(WIN_MAX+1) bits
//   NUM_CH     channels sharing the control stream (width of mul_en)
//   PIPE_DEPTH stages from the multiply enable to the interpolated output
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   win_dim                   window dimension W (0 or >WIN_MAX acts as 1)
//   pix_val / pix_rdy         input pixel handshake
//   coef_val / coef_en        coefficients valid / latch them for the window
//   lb_enq_val / lb_deq_rdy   line-buffer push current / pop previous row
//   mul_en                    capture the four products, per channel
//   pipe_en                   global datapath stage enable
//   row_cnt / col_cnt         position of the next input pixel
//   out_val / out_rdy         interpolated sample handshake
//   win_done                  one-cycle pulse, the cycle after the last
//                             sample of the window is accepted
//
// Configuration
//   INTERP_UNIT_PERF_CNT_EN   adds saturating stall_cnt[31:0] (stalled
//                             cycles) and win_cnt[15:0] (win_done pulses)
// ---------------------------------------------------------------------------
module interpolation_unit_win_interp_ctrl #(
  parameter int WIN_MAX    = 16,
  parameter int NUM_CH     = 1,
  parameter int PIPE_DEPTH = 2,
  localparam int CW        = $clog2(WIN_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CW-1:0]     win_dim,
  input  logic              pix_val,
  output logic              pix_rdy,
  input  logic              coef_val,
  output logic              coef_en,
  output logic              lb_enq_val,
  output logic              lb_deq_rdy,
  output logic [NUM_CH-1:0] mul_en,
  output logic              pipe_en,
  output logic [CW-1:0]     row_cnt,
  output logic [CW-1:0]     col_cnt,
  output logic              out_val,
  input  logic              out_rdy,
  output logic              win_done
`ifdef INTERP_UNIT_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       win_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    S_CALC,
    CALC,
    DRAIN
  } state_t;

  localparam logic [CW-1:0] WIN_MAX_C = CW'(WIN_MAX);

  state_t                state_q, state_d;
  logic [CW-1:0]         w_q, w_d;
  logic [CW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [PIPE_DEPTH-1:0] vld_q;
  logic                  win_done_q, win_done_d;

  logic                  stall;
  logic                  advance;
  logic                  xfer;
  logic                  launch;
  logic                  last_col;
  logic                  last_row;
  logic                  upstream_busy;
  logic                  drain_done;
  logic [CW-1:0]         win_dim_legal;

  // Handshake and stall
  assign out_val = vld_q[PIPE_DEPTH-1];
  assign stall   = out_val & ~out_rdy;
  assign advance = ~stall;
  assign pix_rdy = advance & ((state_q == FILL) || (state_q == S_CALC) || (state_q == CALC));
  assign xfer    = pix_val & pix_rdy;

  // The pipeline is always empty in IDLE, so gating the enable there changes
  // nothing in the datapath and keeps every output low while idle / in reset.
  assign pipe_en = advance & (state_q != IDLE);

  assign last_col = (col_q == w_q);
  assign last_row = (row_q == w_q);

  // Out-of-range dimensions degrade to the smallest window.
  assign win_dim_legal = ((win_dim == '0) || (win_dim > WIN_MAX_C)) ? CW'(1) : win_dim;

  // Any launch still travelling behind the output stage?
  generate
    if (PIPE_DEPTH > 1) begin : g_busy
      assign upstream_busy = |vld_q[PIPE_DEPTH-2:0];
    end else begin : g_no_busy
      assign upstream_busy = 1'b0;
    end
  endgenerate

  assign drain_done = (state_q == DRAIN) & out_val & out_rdy & ~upstream_busy;

  assign mul_en   = {NUM_CH{launch}};
  assign row_cnt  = row_q;
  assign col_cnt  = col_q;
  assign win_done = win_done_q;

  // Next-state / output decode
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    w_d        = w_q;
    row_d      = row_q;
    col_d      = col_q;
    coef_en    = 1'b0;
    lb_enq_val = 1'b0;
    lb_deq_rdy = 1'b0;
    launch     = 1'b0;
    win_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (coef_val) begin
          w_d     = win_dim_legal;
          coef_en = 1'b1;
          row_d   = '0;
          col_d   = '0;
          state_d = FILL;
        end
      end

      // Row 0: only fills the line buffer.
      FILL: begin
        if (xfer) begin
          lb_enq_val = 1'b1;
          if (last_col) begin
            col_d   = '0;
            row_d   = CW'(1);
            state_d = S_CALC;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end

      // Column 0 of rows >= 1: primes the left neighbour, no sample.
      S_CALC: begin
        if (xfer) begin
          lb_enq_val = 1'b1;
          lb_deq_rdy = 1'b1;
          col_d      = CW'(1);
          state_d    = CALC;
        end
      end

      CALC: begin
        if (xfer) begin
          lb_enq_val = 1'b1;
          lb_deq_rdy = 1'b1;
          launch     = 1'b1;
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = DRAIN;
            end else begin
              row_d   = row_q + CW'(1);
              state_d = S_CALC;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end

      DRAIN: begin
        if (drain_done) begin
          win_done_d = 1'b1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, counters and launch pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      w_q        <= CW'(1);
      row_q      <= '0;
      col_q      <= '0;
      vld_q      <= '0;
      win_done_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      w_q        <= w_d;
      row_q      <= row_d;
      col_q      <= col_d;
      win_done_q <= win_done_d;
      // Whole shift register freezes while the output is stalled, which
      // keeps it aligned with the frozen datapath.
      if (advance) begin
        vld_q <= (vld_q << 1) | PIPE_DEPTH'(launch);
      end
    end
  end

`ifdef INTERP_UNIT_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      win_cnt   <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (win_done_q && (win_cnt != '1)) begin
        win_cnt <= win_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_interpolation_unit_win_interp_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for interpolation_unit_win_interp_ctrl.
// A negedge monitor holds a transaction-level model of one window: the
// ordered list of (row, col) pixels, a queue of launched samples ageing by
// one per unstalled cycle, and the window phase. Every cycle it predicts
// all outputs. Directed windows (table and hand sequences) and randomized
// windows check aggregate counts on top of that.
// ---------------------------------------------------------------------------
module tb_interpolation_unit_win_interp_ctrl;

  localparam int WIN_MAX    = 16;
  localparam int NUM_CH     = 2;
  localparam int PIPE_DEPTH = 3;
  localparam int CW         = $clog2(WIN_MAX + 1);

  logic              clk = 1'b0;
  logic              reset_n;
  logic [CW-1:0]     win_dim;
  logic              pix_val;
  logic              pix_rdy;
  logic              coef_val;
  logic              coef_en;
  logic              lb_enq_val;
  logic              lb_deq_rdy;
  logic [NUM_CH-1:0] mul_en;
  logic              pipe_en;
  logic [CW-1:0]     row_cnt;
  logic [CW-1:0]     col_cnt;
  logic              out_val;
  logic              out_rdy;
  logic              win_done;
`ifdef INTERP_UNIT_PERF_CNT_EN
  logic [31:0]       stall_cnt;
  logic [15:0]       win_cnt;
`endif

  interpolation_unit_win_interp_ctrl #(
    .WIN_MAX   (WIN_MAX),
    .NUM_CH    (NUM_CH),
    .PIPE_DEPTH(PIPE_DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .win_dim   (win_dim),
    .pix_val   (pix_val),
    .pix_rdy   (pix_rdy),
    .coef_val  (coef_val),
    .coef_en   (coef_en),
    .lb_enq_val(lb_enq_val),
    .lb_deq_rdy(lb_deq_rdy),
    .mul_en    (mul_en),
    .pipe_en   (pipe_en),
    .row_cnt   (row_cnt),
    .col_cnt   (col_cnt),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .win_done  (win_done)
`ifdef INTERP_UNIT_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .win_cnt   (win_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int legal_w(input int wd);
    return (wd == 0 || wd > WIN_MAX) ? 1 : wd;
  endfunction

  // ---------------- reference model + observation counters ----------------
  int m_phase;        // 0 idle, 1 accepting pixels, 2 waiting for last sample
  int m_w, m_r, m_c;  // window size and next expected pixel position
  int q_age[$];       // unstalled cycles elapsed since each launch
  bit m_done_now;
  int m_launch_cyc;

  int obs_samples = 0;
  int obs_deq     = 0;
  int obs_dones   = 0;
  int obs_stalls  = 0;
  int obs_out_cyc = 0;
  int obs_done_cyc = 0;

  always @(negedge clk) begin : monitor
    bit e_out_val, e_stall, e_pix_rdy, e_xfer, e_launch;
    int ph;
    if (!reset_n) begin
      m_phase    = 0;
      m_w        = 1;
      m_r        = 0;
      m_c        = 0;
      m_done_now = 0;
      obs_stalls = 0;
      q_age.delete();
    end else begin
      ph        = m_phase;
      e_out_val = (q_age.size() > 0) && (q_age[0] == PIPE_DEPTH);
      e_stall   = e_out_val && !out_rdy;
      e_pix_rdy = (ph == 1) && !e_stall;
      e_xfer    = e_pix_rdy && pix_val;
      e_launch  = e_xfer && (m_r >= 1) && (m_c >= 1);

      check("out_val",    int'(out_val),    int'(e_out_val));
      check("pix_rdy",    int'(pix_rdy),    int'(e_pix_rdy));
      check("pipe_en",    int'(pipe_en),    int'((ph != 0) && !e_stall));
      check("coef_en",    int'(coef_en),    int'((ph == 0) && coef_val));
      check("lb_enq_val", int'(lb_enq_val), int'(e_xfer));
      check("lb_deq_rdy", int'(lb_deq_rdy), int'(e_xfer && (m_r >= 1)));
      check("mul_en",     int'(mul_en),     e_launch ? (1 << NUM_CH) - 1 : 0);
      check("row_cnt",    int'(row_cnt),    (ph == 1) ? m_r : 0);
      check("col_cnt",    int'(col_cnt),    (ph == 1) ? m_c : 0);
      check("win_done",   int'(win_done),   int'(m_done_now));

      if (out_val && out_rdy) begin obs_samples++; obs_out_cyc = cyc; end
      if (out_val && !out_rdy) obs_stalls++;
      if (lb_deq_rdy) obs_deq++;
      if (win_done) begin obs_dones++; obs_done_cyc = cyc; end

      m_done_now = 0;
      if (e_out_val && out_rdy) void'(q_age.pop_front());
      if (e_launch) begin q_age.push_back(0); m_launch_cyc = cyc; end
      if (!e_stall) foreach (q_age[i]) q_age[i]++;
      if (ph == 2 && e_out_val && out_rdy && q_age.size() == 0) begin
        m_phase    = 0;
        m_done_now = 1;
      end
      if (e_xfer) begin
        if (m_c == m_w) begin
          m_c = 0;
          if (m_r == m_w) m_phase = 2;
          else m_r++;
        end else begin
          m_c++;
        end
      end
      if (ph == 0 && coef_val) begin
        m_w = legal_w(int'(win_dim));
        m_phase = 1;
        m_r = 0;
        m_c = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_window(input int wd, input int wd_after, input int val_pct,
                            input int rdy_pct, input bit rand_wd, input int stall_at,
                            input int stall_len, output int samples, output int deqs,
                            output int dones);
    int s0, d0, n0, stall_left;
    bit stall_used, finished;
    s0 = obs_samples; d0 = obs_deq; n0 = obs_dones;
    @(posedge clk); #1;
    win_dim = CW'(wd); coef_val = 1'b1; pix_val = 1'b0; out_rdy = 1'b1;
    @(posedge clk); #1;
    coef_val = 1'b0; win_dim = CW'(wd_after);
    stall_left = 0; stall_used = 0; finished = 0;
    for (int k = 0; k < 20000 && !finished; k++) begin
      pix_val = ($urandom_range(0, 99) < val_pct);
      if (rand_wd) win_dim = CW'($urandom);
      if (!stall_used && stall_at >= 0 && (obs_samples - s0) >= stall_at && out_val) begin
        stall_used = 1;
        stall_left = stall_len;
      end
      if (stall_left > 0) begin
        out_rdy = 1'b0;
        stall_left--;
      end else begin
        out_rdy = ($urandom_range(0, 99) < rdy_pct);
      end
      @(posedge clk); #1;
      if (obs_dones != n0) finished = 1;
    end
    check("window_timeout", int'(finished), 1);
    pix_val = 1'b0; out_rdy = 1'b1;
    samples = obs_samples - s0;
    deqs    = obs_deq - d0;
    dones   = obs_dones - n0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  typedef struct {
    int wd;
    int exp_samples;
    int exp_deq;
  } vec_t;

  vec_t vecs[$];
  int   s, d, n, st0, n0;

  initial begin
    reset_n = 1'b0; win_dim = '0; pix_val = 1'b0; coef_val = 1'b0; out_rdy = 1'b1;

    // Reset state
    #2;
    check("rst_pix_rdy", int'(pix_rdy), 0);
    check("rst_out_val", int'(out_val), 0);
    check("rst_pipe_en", int'(pipe_en), 0);
    check("rst_row_col", int'({row_cnt, col_cnt}), 0);
    check("rst_win_done", int'(win_done), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // 1: W=1, latency PIPE_DEPTH, win_done one cycle after the sample
    run_window(1, 1, 100, 100, 0, -1, 0, s, d, n);
    check("t1_samples", s, 1);
    check("t1_dones", n, 1);
    check("t1_latency", obs_out_cyc - m_launch_cyc, PIPE_DEPTH);
    check("t1_done_gap", obs_done_cyc - obs_out_cyc, 1);

    // Table: continuous windows, including illegal sizes that act as W=1
    vecs = '{'{1, 1, 2}, '{4, 16, 20}, '{15, 225, 240}, '{16, 256, 272},
             '{0, 1, 2}, '{17, 1, 2}, '{31, 1, 2}};
    foreach (vecs[i]) begin
      run_window(vecs[i].wd, vecs[i].wd, 100, 100, 0, -1, 0, s, d, n);
      check($sformatf("tab%0d_samples", i), s, vecs[i].exp_samples);
      check($sformatf("tab%0d_deq", i), d, vecs[i].exp_deq);
      check($sformatf("tab%0d_dones", i), n, 1);
    end

    // 3: W=4, five stalled cycles mid-window
    st0 = obs_stalls;
    run_window(4, 4, 100, 100, 0, 5, 5, s, d, n);
    check("t3_samples", s, 16);
    check("t3_stalls", obs_stalls - st0, 5);
    check("t3_dones", n, 1);

    // 4: win_dim 4 -> 8 mid-window is ignored; next window uses 8
    run_window(4, 8, 100, 100, 0, -1, 0, s, d, n);
    check("t4a_samples", s, 16);
    run_window(8, 8, 100, 100, 0, -1, 0, s, d, n);
    check("t4b_samples", s, 64);

    // Randomized windows with random backpressure and jittering win_dim
    for (int r = 0; r < 6; r++) begin
      int wd;
      wd = $urandom_range(0, 31);
      run_window(wd, wd, 70, 70, 1, -1, 0, s, d, n);
      check($sformatf("rnd%0d_samples", r), s, legal_w(wd) * legal_w(wd));
      check($sformatf("rnd%0d_deq", r), d, legal_w(wd) * (legal_w(wd) + 1));
      check($sformatf("rnd%0d_dones", r), n, 1);
    end

    // 5: reset during row 2 of W=6 aborts the window
    @(posedge clk); #1;
    win_dim = CW'(6); coef_val = 1'b1;
    @(posedge clk); #1;
    coef_val = 1'b0; pix_val = 1'b1; out_rdy = 1'b1;
    for (int k = 0; k < 200 && !(m_phase == 1 && m_r == 2 && m_c == 3); k++) begin
      @(posedge clk); #1;
    end
    check("t5_reached_row2", int'(row_cnt), 2);
    n0 = obs_dones;
    #2 reset_n = 1'b0;
    #1;
    check("t5_out_val", int'(out_val), 0);
    check("t5_pix_rdy", int'(pix_rdy), 0);
    check("t5_enq_deq", int'({lb_enq_val, lb_deq_rdy}), 0);
    check("t5_mul_pipe", int'({mul_en, pipe_en}), 0);
    check("t5_row_col", int'({row_cnt, col_cnt}), 0);
    pix_val = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    check("t5_no_done", obs_dones - n0, 0);
    run_window(6, 6, 100, 100, 0, -1, 0, s, d, n);
    check("t5_samples", s, 36);
    check("t5_dones", n, 1);

    // 6: three W=2 windows after reset, seven stalled cycles in total
    pulse_reset();
    run_window(2, 2, 100, 100, 0, 1, 7, s, d, n);
    check("t6a_samples", s, 4);
    run_window(2, 2, 100, 100, 0, -1, 0, s, d, n);
    check("t6b_samples", s, 4);
    run_window(2, 2, 100, 100, 0, -1, 0, s, d, n);
    check("t6c_samples", s, 4);
    check("t6_stalls", obs_stalls, 7);
`ifdef INTERP_UNIT_PERF_CNT_EN
    check("t6_stall_cnt", int'(stall_cnt), 7);
    check("t6_win_cnt", int'(win_cnt), 3);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
